// File: rtl/slice_stream_fifo.sv
// rtl/slice_stream_fifo.sv - 64-bit slicer-to-stream FIFO with registered output and optional stats (SLICE_FIFO_STATS_EN)
// Occupancy counts every stored beat, including the one currently presented on o_data.
module slice_stream_fifo #(
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic        i_user_clk,
  input  logic        i_rst,
  input  logic        i_data_valid,
  input  logic [63:0] i_data,
  output logic        o_ack,
  output logic        o_data_valid,
  output logic [63:0] o_data,
  input  logic        i_ack,
  input  logic [19:0] i_user_addr,
  input  logic        i_user_wr_req,
  input  logic        i_user_rd_req,
  output logic [31:0] o_user_data,
  output logic        o_user_rd_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic [63:0]      data_q, data_d;
  logic             rd_ack_q, rd_ack_d;
  logic             full, pop, wr, overflow;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    pop      = valid_q & i_ack;
    wr       = i_data_valid & (~full | pop);
    overflow = i_data_valid & full & ~pop;

    wr_ptr_d = wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (wr && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !wr) begin
      count_d = count_q - CNT_W'(1);
    end

    valid_d = (count_d != '0);
    rd_ack_d = i_user_rd_req;

    // The incoming beat becomes the new head when nothing older remains after this pop.
    data_d = data_q;
    if (count_d != '0) begin
      if (wr && ((count_q == '0) || ((count_q == CNT_W'(1)) && pop))) begin
        data_d = i_data;
      end else begin
        data_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge i_user_clk) begin
    if (wr) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge i_user_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      rd_ack_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      rd_ack_q <= rd_ack_d;
    end
  end

  assign o_ack         = (count_q < CNT_W'(AFULL_THRESH));
  assign o_data_valid  = valid_q;
  assign o_data        = data_q;
  assign o_user_rd_ack = rd_ack_q;

`ifdef SLICE_FIFO_STATS_EN
  logic [31:0] ovf_cnt_q, ovf_cnt_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [31:0] user_data_q, user_data_d;
  logic        clr_ovf, clr_beat;

  always_comb begin
    clr_ovf  = i_user_wr_req & (i_user_addr == 20'h00014);
    clr_beat = i_user_wr_req & (i_user_addr == 20'h00018);

    ovf_cnt_d = ovf_cnt_q;
    if (clr_ovf) begin
      ovf_cnt_d = '0;
    end else if (overflow && (ovf_cnt_q != 32'hFFFF_FFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 32'd1;
    end

    beat_cnt_d = beat_cnt_q;
    if (clr_beat) begin
      beat_cnt_d = '0;
    end else if (pop) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
    end

    user_data_d = user_data_q;
    if (i_user_rd_req) begin
      case (i_user_addr)
        20'h00010: user_data_d = 32'(count_q);
        20'h00014: user_data_d = ovf_cnt_q;
        20'h00018: user_data_d = beat_cnt_q;
        default:   user_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_user_clk) begin
    if (i_rst) begin
      ovf_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      user_data_q <= '0;
    end else begin
      ovf_cnt_q   <= ovf_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      user_data_q <= user_data_d;
    end
  end

  assign o_user_data = user_data_q;
`else
  logic unused_stats;
  assign unused_stats = ^{i_user_addr, i_user_wr_req, overflow};
  assign o_user_data  = '0;
`endif

endmodule

// File: tb/tb_slice_stream_fifo.sv
// tb/tb_slice_stream_fifo.sv - directed bench with queue-based reference model for slice_stream_fifo
module tb_slice_stream_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;
`ifdef SLICE_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_data_valid;
  logic [63:0] i_data;
  logic        o_ack;
  logic        o_data_valid;
  logic [63:0] o_data;
  logic        i_ack;
  logic [19:0] i_user_addr;
  logic        i_user_wr_req;
  logic        i_user_rd_req;
  logic [31:0] o_user_data;
  logic        o_user_rd_ack;

  slice_stream_fifo #(.DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
    .i_user_clk    (clk),
    .i_rst         (rst),
    .i_data_valid  (i_data_valid),
    .i_data        (i_data),
    .o_ack         (o_ack),
    .o_data_valid  (o_data_valid),
    .o_data        (o_data),
    .i_ack         (i_ack),
    .i_user_addr   (i_user_addr),
    .i_user_wr_req (i_user_wr_req),
    .i_user_rd_req (i_user_rd_req),
    .o_user_data   (o_user_data),
    .o_user_rd_ack (o_user_rd_ack)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of stored beats plus event counters.
  logic [63:0] mq[$];
  logic [31:0] m_ovf = 0;
  logic [31:0] m_pops = 0;
  bit          m_rd_ack = 0;
  logic [31:0] m_user_data = 0;
  bit          m_live = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      m_pops = 0;
      m_rd_ack = 0;
      m_live = 1;
    end else begin
      bit p;
      bit w;
      m_rd_ack = i_user_rd_req;
      if (i_user_rd_req) begin
        if (!STATS) m_user_data = 0;
        else if (i_user_addr == 20'h10) m_user_data = 32'(mq.size());
        else if (i_user_addr == 20'h14) m_user_data = m_ovf;
        else if (i_user_addr == 20'h18) m_user_data = m_pops;
        else m_user_data = 0;
      end
      p = (mq.size() > 0) && i_ack;
      w = i_data_valid && ((mq.size() < DEPTH) || p);
      if (p) begin
        void'(mq.pop_front());
        m_pops = m_pops + 1;
      end
      if (w) mq.push_back(i_data);
      if (i_data_valid && !w && m_ovf != 32'hFFFF_FFFF) m_ovf = m_ovf + 1;
      if (i_user_wr_req && i_user_addr == 20'h14) m_ovf = 0;
      if (i_user_wr_req && i_user_addr == 20'h18) m_pops = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("cmp_valid", o_data_valid, (mq.size() > 0));
      if (mq.size() > 0) chk("cmp_data", o_data, mq[0]);
      chk("cmp_ack", o_ack, (mq.size() < AFULL));
      chk("cmp_rd_ack", o_user_rd_ack, m_rd_ack);
      if (m_rd_ack) chk("cmp_user_data", o_user_data, m_user_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_read(input logic [19:0] a, input logic [31:0] e, input string name);
    i_user_addr = a;
    i_user_rd_req = 1'b1;
    step();
    i_user_rd_req = 1'b0;
    chk({name, "_rd_ack"}, o_user_rd_ack, 1'b1);
    chk(name, o_user_data, e);
    step();
    chk({name, "_rd_ack_drop"}, o_user_rd_ack, 1'b0);
  endtask

  initial begin
    int sent;
    int cyc;
    rst = 1'b1;
    i_data_valid = 1'b0;
    i_data = '0;
    i_ack = 1'b0;
    i_user_addr = '0;
    i_user_wr_req = 1'b0;
    i_user_rd_req = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_valid", o_data_valid, 1'b0);
    chk("rst_ack", o_ack, 1'b1);
    chk("rst_data", o_data, 64'h0);
    chk("rst_rd_ack", o_user_rd_ack, 1'b0);

    // Single beat through an empty FIFO
    i_ack = 1'b1;
    i_data_valid = 1'b1;
    i_data = 64'h0123_4567_89AB_CDEF;
    step();
    i_data_valid = 1'b0;
    chk("t1_valid", o_data_valid, 1'b1);
    chk("t1_data", o_data, 64'h0123_4567_89AB_CDEF);
    step();
    chk("t1_empty", o_data_valid, 1'b0);

    // Fill to full, then one dropped beat
    i_ack = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      i_data_valid = 1'b1;
      i_data = 64'hA5A5_0000_0000_0000 | 64'(k);
      step();
      if (k == 11) chk("t2_ack_after_11", o_ack, 1'b1);
      if (k == 12) chk("t2_ack_after_12", o_ack, 1'b0);
    end
    i_data_valid = 1'b0;
    chk("t2_model_size", 64'(mq.size()), 64'd16);
    chk("t2_model_ovf", m_ovf, 64'd1);
    chk("t2_head", o_data, 64'hA5A5_0000_0000_0001);
    reg_read(20'h14, STATS ? 32'd1 : 32'd0, "t2_ovf_reg");

    // Full with simultaneous write and pop across pointer wrap
    i_ack = 1'b1;
    for (int k = 0; k < 40; k++) begin
      i_data_valid = 1'b1;
      i_data = 64'hC3C3_0000_0000_0000 | 64'(k);
      step();
    end
    i_data_valid = 1'b0;
    i_ack = 1'b0;
    chk("t3_model_size", 64'(mq.size()), 64'd16);
    chk("t3_model_ovf", m_ovf, 64'd1);
    chk("t3_head", o_data, 64'hC3C3_0000_0000_0018);
    reg_read(20'h10, STATS ? 32'd16 : 32'd0, "t3_occ_reg");
    reg_read(20'h14, STATS ? 32'd1 : 32'd0, "t3_ovf_reg");
    i_ack = 1'b1;
    repeat (20) step();
    i_ack = 1'b0;
    chk("t3_model_pops", m_pops, 64'd57);
    chk("t3_drained", o_data_valid, 1'b0);
    reg_read(20'h18, STATS ? 32'd57 : 32'd0, "t3_beat_reg");

    // 1000 beats with random downstream stalls
    i_user_addr = 20'h18;
    i_user_wr_req = 1'b1;
    step();
    i_user_wr_req = 1'b0;
    sent = 0;
    cyc = 0;
    while ((sent < 1000 || mq.size() > 0) && cyc < 20000) begin
      i_ack = 1'($urandom_range(0, 1));
      if (sent < 1000 && o_ack) begin
        i_data_valid = 1'b1;
        i_data = 64'h1000_0000_0000_0000 + 64'(sent);
        sent++;
      end else begin
        i_data_valid = 1'b0;
      end
      step();
      cyc++;
    end
    i_data_valid = 1'b0;
    i_ack = 1'b0;
    chk("t4_in_time", cyc < 20000, 1'b1);
    chk("t4_model_pops", m_pops, 64'd1000);
    chk("t4_model_ovf", m_ovf, 64'd1);
    reg_read(20'h18, STATS ? 32'd1000 : 32'd0, "t4_beat_reg");

    // Reset mid-transfer flushes stored beats
    for (int k = 0; k < 8; k++) begin
      i_data_valid = 1'b1;
      i_data = 64'hD0D0_0000_0000_0000 | 64'(k);
      step();
    end
    chk("t5_model_size", 64'(mq.size()), 64'd8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_data_valid = 1'b0;
    chk("t5_valid", o_data_valid, 1'b0);
    chk("t5_ack", o_ack, 1'b1);
    chk("t5_data", o_data, 64'h0);
    i_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t5_no_emit", o_data_valid, 1'b0);
    end
    reg_read(20'h14, 32'd0, "t5_ovf_reg");
    reg_read(20'h18, 32'd0, "t5_beat_reg");

    // Overflow again, then clear racing an overflow
    i_ack = 1'b0;
    for (int k = 0; k < 17; k++) begin
      i_data_valid = 1'b1;
      i_data = 64'hE0E0_0000_0000_0000 | 64'(k);
      step();
    end
    i_data_valid = 1'b0;
    reg_read(20'h14, STATS ? 32'd1 : 32'd0, "t6_ovf_reg");
    i_data_valid = 1'b1;
    i_user_addr = 20'h14;
    i_user_wr_req = 1'b1;
    step();
    i_data_valid = 1'b0;
    i_user_wr_req = 1'b0;
    chk("t6_model_clear", m_ovf, 64'd0);
    reg_read(20'h14, 32'd0, "t6_clear_wins");
    reg_read(20'h20, 32'd0, "t6_other_addr");
    i_ack = 1'b1;
    repeat (20) step();
    chk("t6_drained", o_data_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/slice_stream_fifo.md
SLICE_STREAM_FIFO -- requirements
Module: slice_stream_fifo

Interface
REQ-001 Parameter DEPTH, 16, FIFO depth in 64-bit beats; power of two, 4..256.
REQ-002 Parameter AFULL_THRESH, 12, occupancy at or above which o_ack deasserts; 1..DEPTH-1.
REQ-003 i_user_clk  input  1  single clock; all logic rising-edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_data_valid  input  1  upstream slicer beat valid; upstream may ignore o_ack.
REQ-006 i_data  input  64  upstream sliced data, 8 bytes per beat.
REQ-007 o_ack  output  1  upstream flow control: high = space available.
REQ-008 o_data_valid  output  1  downstream beat valid (toward PCIe stream).
REQ-009 o_data  output  64  downstream data.
REQ-010 i_ack  input  1  downstream accepts beat when high with o_data_valid.
REQ-011 i_user_addr  input  20  register address (stats read/clear).
REQ-012 i_user_wr_req  input  1  register write strobe.
REQ-013 i_user_rd_req  input  1  register read strobe.
REQ-014 o_user_data  output  32  register read data.
REQ-015 o_user_rd_ack  output  1  read acknowledge.

Function
REQ-016 Write occurs every cycle i_data_valid=1 and (not full, or full with downstream pop same cycle); write ignores o_ack.
REQ-017 Beat with i_data_valid=1 while full and no pop SHALL be dropped, FIFO contents unchanged, overflow event raised.
REQ-018 Pop occurs when o_data_valid=1 and i_ack=1; next entry presented following cycle.
REQ-019 o_data_valid and o_data SHALL be registered; beat written into empty FIFO appears on o_data_valid exactly 1 cycle after write.
REQ-020 o_data/o_data_valid SHALL hold stable while o_data_valid=1 and i_ack=0.
REQ-021 Order preserved; no duplication; 64-bit beat stored intact.
REQ-022 Occupancy counter 0..DEPTH: +1 write only, -1 pop only, unchanged on simultaneous write and pop (including at full and at 1).
REQ-023 o_ack = (occupancy < AFULL_THRESH), combinational from registered occupancy.
REQ-024 Read/write pointers wrap modulo DEPTH without gap.
REQ-025 o_user_rd_ack SHALL equal i_user_rd_req delayed one cycle; o_user_data valid in same cycle as o_user_rd_ack.

Reset
REQ-026 While i_rst=1 at clock edge: pointers, occupancy, o_data_valid cleared, o_data=0, o_ack=1 after edge, o_user_rd_ack=0, stats counters 0.
REQ-027 Reset mid-transfer SHALL flush all stored beats; beats presented during reset cycles dropped, not counted as overflow.

Configuration
REQ-028 Macro SLICE_FIFO_STATS_EN defined: registers 0x10 = occupancy (zero-extended), 0x14 = overflow count (32-bit, saturating at 0xFFFFFFFF), 0x18 = popped beat count (32-bit, wrapping); other addresses read 0.
REQ-029 With SLICE_FIFO_STATS_EN: write to address 0x14 clears overflow count; write to 0x18 clears beat count; clear wins over same-cycle increment (result 0).
REQ-030 Without SLICE_FIFO_STATS_EN: no counters synthesised, o_user_data=0 always, writes ignored, o_user_rd_ack timing unchanged.

Verification
REQ-031 Reset, write 0x0123456789ABCDEF with i_ack=1 -> o_data_valid high next cycle with same data, occupancy returns 0.
REQ-032 i_ack=0, 12 consecutive writes -> o_ack low after 12th write; 16 writes -> full; 17th beat dropped, overflow count 1 (stats on).
REQ-033 Full FIFO, i_ack=1 and i_data_valid=1 same cycle for 40 cycles -> occupancy stays 16, no drops, output order matches input order across pointer wrap.
REQ-034 i_ack toggled 1/0 randomly with 1000 incrementing beats, no overflow -> all 1000 out in order, beat count reads 1000 at 0x18.
REQ-035 8 beats stored, i_rst pulsed 1 cycle -> o_data_valid 0 next cycle, o_ack 1, stored beats never emitted.
REQ-036 Stats off build: read 0x14 after overflow -> o_user_rd_ack 1 cycle later, o_user_data 0.
